radio_ctrl_processor: RTL and testbench

Control-packet processor for a radio block. It accepts 64-bit AXI-Stream control packets, either immediate or timed against a 64-bit VITA time counter. It executes each packet as a single settings-bus write and optionally returns a two-word acknowledgement packet. It sits between the crossbar control FIFO and the radio's settings registers.

---
 rtl/radio_ctrl_processor_pkg.sv | 31 +++
 rtl/radio_ctrl_processor.sv | 143 ++++++++++++++
 tb/tb_radio_ctrl_processor.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/radio_ctrl_processor_pkg.sv
// Shared definitions for the radio control-packet processor: FSM encoding,
// command header field positions and response header construction.
package radio_ctrl_processor_pkg;

  typedef enum logic [3:0] {
    StHead     = 4'd0,
    StTime     = 4'd1,
    StData     = 4'd2,
    StDrop     = 4'd3,
    StWait     = 4'd4,
    StRespHead = 4'd5,
    StRespData = 4'd6
  } state_e;

  localparam int unsigned HdrEcBit      = 63;
  localparam int unsigned HdrHasTimeBit = 61;
  localparam int unsigned HdrSeqLsb     = 48;
  localparam int unsigned SeqWidth      = 12;
  localparam int unsigned PayAddrLsb    = 32;

  localparam logic [15:0] RespLen  = 16'd16;
  localparam logic [1:0]  RespType = 2'b11;

  // Response header carries the sid with its halves swapped (src/dst exchange).
  function automatic logic [63:0] resp_header(input logic        late,
                                              input logic [11:0] seqnum,
                                              input logic [31:0] sid);
    return {RespType, 1'b0, late, seqnum, RespLen, sid[15:0], sid[31:16]};
  endfunction

endpackage

// File: rtl/radio_ctrl_processor.sv
// Executes immediate or timed control packets as single settings-bus writes and
// optionally returns a two-word acknowledgement packet.
module radio_ctrl_processor
  import radio_ctrl_processor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [63:0] ctrl_tdata,
  input  logic        ctrl_tlast,
  input  logic        ctrl_tvalid,
  output logic        ctrl_tready,
  output logic [63:0] resp_tdata,
  output logic        resp_tlast,
  output logic        resp_tvalid,
  input  logic        resp_tready,
  input  logic [63:0] vita_time,
  input  logic        ready,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic [31:0] debug
);

  state_e      state_q, state_d;
  logic        srst;
  logic        ctrl_hs;
  logic        ec_q, has_time_q, late_q, wait_first_q;
  logic [11:0] seqnum_q;
  logic [31:0] sid_q, data_q;
  logic [7:0]  addr_q;
  logic [63:0] time_q;
  logic        late_now, time_ok, exec, skip;
  logic        set_stb_q;
  logic [7:0]  set_addr_q;
  logic [31:0] set_data_q;
  logic        unused_tdata;

  assign srst    = reset | clear;
  assign ctrl_hs = ctrl_tvalid & ctrl_tready;

  // Lateness is judged only on the first cycle of the wait; afterwards the
  // command simply waits for time and ready.
  assign late_now = has_time_q & wait_first_q & (vita_time > time_q);
  assign time_ok  = ~has_time_q | (vita_time >= time_q);
  assign exec     = (state_q == StWait) & ~late_now & time_ok & ready;
  assign skip     = (state_q == StWait) & late_now;

  assign unused_tdata = ^{ctrl_tdata[62], ctrl_tdata[60], ctrl_tdata[47:40]};

  always_ff @(posedge clk) begin
    if (srst) state_q <= StHead;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHead: begin
        if (ctrl_hs) begin
          if (ctrl_tlast)                      state_d = StHead;
          else if (ctrl_tdata[HdrHasTimeBit])  state_d = StTime;
          else                                 state_d = StData;
        end
      end
      StTime:     if (ctrl_hs) state_d = ctrl_tlast ? StHead : StData;
      StData:     if (ctrl_hs) state_d = ctrl_tlast ? StWait : StDrop;
      StDrop:     if (ctrl_hs && ctrl_tlast) state_d = StHead;
      StWait:     if (exec || skip) state_d = ec_q ? StRespHead : StHead;
      StRespHead: if (resp_tready) state_d = StRespData;
      StRespData: if (resp_tready) state_d = StHead;
      default:    state_d = StHead;
    endcase
  end

  always_comb begin
    ctrl_tready = 1'b0;
    resp_tvalid = 1'b0;
    resp_tlast  = 1'b0;
    resp_tdata  = '0;
    unique case (state_q)
      StHead, StTime, StData, StDrop: ctrl_tready = ~srst;
      StRespHead: begin
        resp_tvalid = 1'b1;
        resp_tdata  = resp_header(late_q, seqnum_q, sid_q);
      end
      StRespData: begin
        resp_tvalid = 1'b1;
        resp_tlast  = 1'b1;
        resp_tdata  = {31'd0, late_q, data_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ec_q         <= 1'b0;
      has_time_q   <= 1'b0;
      seqnum_q     <= '0;
      sid_q        <= '0;
      time_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      late_q       <= 1'b0;
      wait_first_q <= 1'b0;
      set_stb_q    <= 1'b0;
      set_addr_q   <= '0;
      set_data_q   <= '0;
    end else begin
      wait_first_q <= (state_d == StWait) && (state_q != StWait);
      set_stb_q    <= exec;
      if (exec) begin
        set_addr_q <= addr_q;
        set_data_q <= data_q;
      end
      if (skip) late_q <= 1'b1;
      if (ctrl_hs) begin
        unique case (state_q)
          StHead: begin
            ec_q       <= ctrl_tdata[HdrEcBit];
            has_time_q <= ctrl_tdata[HdrHasTimeBit];
            seqnum_q   <= ctrl_tdata[HdrSeqLsb +: SeqWidth];
            sid_q      <= ctrl_tdata[31:0];
            late_q     <= 1'b0;
          end
          StTime: time_q <= ctrl_tdata;
          StData: begin
            addr_q <= ctrl_tdata[PayAddrLsb +: 8];
            data_q <= ctrl_tdata[31:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign set_stb  = set_stb_q;
  assign set_addr = set_addr_q;
  assign set_data = set_data_q;
  assign debug    = {28'h0, state_q};

endmodule

// File: tb/tb_radio_ctrl_processor.sv
// Scoreboard bench for radio_ctrl_processor: driver pushes expected writes and
// response words, a negedge monitor pops and compares them.
module tb_radio_ctrl_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [63:0] ctrl_tdata = '0;
  logic        ctrl_tlast = 1'b0;
  logic        ctrl_tvalid = 1'b0;
  logic        ctrl_tready;
  logic [63:0] resp_tdata;
  logic        resp_tlast, resp_tvalid;
  logic        resp_tready = 1'b1;
  logic [63:0] vita_time = '0;
  logic        ready = 1'b1;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] debug;

  int checks = 0;
  int errors = 0;
  bit ready_rand = 1'b0;
  bit resp_rand = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    bit          chk_time;
    logic [63:0] at;
  } wr_t;

  wr_t         wr_q[$];
  logic [64:0] rsp_q[$];
  wr_t         mon_w;
  logic        ready_prev = 1'b1;
  bit          hold_pending = 1'b0;
  logic [64:0] hold_word;

  radio_ctrl_processor dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .ctrl_tdata  (ctrl_tdata),
    .ctrl_tlast  (ctrl_tlast),
    .ctrl_tvalid (ctrl_tvalid),
    .ctrl_tready (ctrl_tready),
    .resp_tdata  (resp_tdata),
    .resp_tlast  (resp_tlast),
    .resp_tvalid (resp_tvalid),
    .resp_tready (resp_tready),
    .vita_time   (vita_time),
    .ready       (ready),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .debug       (debug)
  );

  always #5 clk = ~clk;

  // Time base, radio ready and downstream ready all change just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      vita_time   = vita_time + 64'd1;
      ready       = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      resp_tready = resp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (set_stb) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_set_stb actual addr=%h data=%h required no strobe",
                 set_addr, set_data);
      end else begin
        mon_w = wr_q.pop_front();
        chk("set_addr", 96'(set_addr), 96'(mon_w.addr));
        chk("set_data", 96'(set_data), 96'(mon_w.data));
        chk("set_ready_prev", 96'(ready_prev), 96'd1);
        if (mon_w.chk_time) chk("set_stb_time", 96'(vita_time), 96'(mon_w.at));
      end
    end
    ready_prev = ready;

    if (hold_pending && !(reset || clear)) begin
      chk("resp_hold_valid", 96'(resp_tvalid), 96'd1);
      chk("resp_hold_word", 96'({resp_tlast, resp_tdata}), 96'(hold_word));
    end
    hold_pending = resp_tvalid && !resp_tready && !(reset || clear);
    hold_word    = {resp_tlast, resp_tdata};

    if (resp_tvalid && resp_tready) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=%h required no response", resp_tdata);
      end else begin
        chk("resp_word", 96'({resp_tlast, resp_tdata}), 96'(rsp_q.pop_front()));
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic l, output logic [63:0] v);
    int n;
    ctrl_tdata  = d;
    ctrl_tlast  = l;
    ctrl_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ctrl_tready) break;
      n++;
      if (n > 2000) begin
        $display("FAIL ctrl_tready_timeout actual=0 required=1");
        $fatal(1, "ctrl_tready never asserted");
      end
    end
    v = vita_time;
    @(posedge clk);
    #1;
    ctrl_tvalid = 1'b0;
  endtask

  // kind: 0 normal, 1 tlast on header, 2 tlast on time word, 3 extra payload word
  task automatic send_cmd(input bit ec, input bit has_time, input logic [63:0] t,
                          input logic [11:0] seq, input logic [31:0] sid,
                          input logic [15:0] addr, input logic [31:0] data,
                          input int kind, input bit expect_it);
    logic [63:0] hdr, pay, v;
    bit          late;
    wr_t         w;
    hdr = {ec, 1'($urandom), has_time, 1'($urandom), seq, 16'($urandom), sid};
    pay = {16'($urandom), addr, data};
    if (kind == 1) begin
      send_word(hdr, 1'b1, v);
      return;
    end
    send_word(hdr, 1'b0, v);
    if (has_time) begin
      if (kind == 2) begin
        send_word(t, 1'b1, v);
        return;
      end
      send_word(t, 1'b0, v);
    end
    if (kind == 3) begin
      send_word(pay, 1'b0, v);
      send_word(~pay, 1'b1, v);
      return;
    end
    send_word(pay, 1'b1, v);
    if (!expect_it) return;
    // The wait begins the cycle after the payload is accepted, i.e. at time v+1.
    late = has_time && (t < v + 64'd1);
    if (!late) begin
      w.addr     = addr[7:0];
      w.data     = data;
      w.chk_time = has_time && !ready_rand;
      w.at       = t + 64'd1;
      wr_q.push_back(w);
    end
    if (ec) begin
      rsp_q.push_back({1'b0, 2'b11, 1'b0, late, seq, 16'd16, sid[15:0], sid[31:16]});
      rsp_q.push_back({1'b1, 31'd0, late, data});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || rsp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_wr_q", 96'(wr_q.size()), 96'd0);
    chk("drain_rsp_q", 96'(rsp_q.size()), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          kind;
    bit          ht;
    logic [63:0] t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_set_stb", 96'(set_stb), 96'd0);
    chk("rst_set_addr", 96'(set_addr), 96'd0);
    chk("rst_set_data", 96'(set_data), 96'd0);
    chk("rst_resp_tvalid", 96'(resp_tvalid), 96'd0);
    chk("rst_resp_tlast", 96'(resp_tlast), 96'd0);
    chk("rst_ctrl_tready", 96'(ctrl_tready), 96'd0);
    chk("rst_debug_upper", 96'(debug[31:4]), 96'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    send_cmd(1, 0, 64'h0,  12'd5, 32'hDEAD_BEEF, 16'h000B, 32'hF00D_1234, 0, 1);
    send_cmd(1, 1, 64'h20, 12'd6, 32'hDEAD_6789, 16'h000C, 32'hABCD_4321, 0, 1);
    send_cmd(1, 1, 64'h30, 12'd7, 32'hDEAD_6789, 16'h000D, 32'h1357_9BDF, 0, 1);
    drain();
    send_cmd(1, 1, 64'h5,  12'd8, 32'h1234_5678, 16'h00AA, 32'h5555_AAAA, 0, 1);
    send_cmd(0, 0, 64'h0,  12'd9, 32'h0BAD_CAFE, 16'h0011, 32'h0000_0077, 0, 1);
    send_cmd(1, 0, 64'h0,  12'd10, 32'h1111_2222, 16'h0022, 32'h3333_4444, 1, 1);
    send_cmd(1, 0, 64'h0,  12'd11, 32'h5555_6666, 16'h0033, 32'h7777_8888, 0, 1);
    send_cmd(1, 1, vita_time + 64'd10, 12'd12, 32'hAAAA_BBBB, 16'h0044, 32'h9999_0000, 2, 1);
    send_cmd(1, 0, 64'h0,  12'd13, 32'hCCCC_DDDD, 16'h0055, 32'h1212_3434, 3, 1);
    send_cmd(1, 0, 64'h0,  12'd14, 32'hEEEE_FFFF, 16'h0066, 32'h5656_7878, 0, 1);
    drain();

    resp_rand = 1'b1;
    send_cmd(1, 0, 64'h0, 12'd15, 32'h0102_0304, 16'h0077, 32'hCAFE_0001, 0, 1);
    send_cmd(1, 1, vita_time + 64'd12, 12'd16, 32'h0506_0708, 16'h0088, 32'hCAFE_0002, 0, 1);
    drain();

    // Abandon a command waiting for its time: via reset, then via clear.
    for (int i = 0; i < 2; i++) begin
      send_cmd(1, 1, vita_time + 64'd40, 12'd17, 32'h0A0B_0C0D, 16'h0099, 32'hBAD0_0000, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      if (i == 0) reset = 1'b1;
      else        clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_ctrl_tready", 96'(ctrl_tready), 96'd0);
      chk("abort_resp_tvalid", 96'(resp_tvalid), 96'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      chk("abort_set_stb", 96'(set_stb), 96'd0);
      chk("abort_head_ready", 96'(ctrl_tready), 96'd1);
      repeat (50) @(posedge clk);
      #1;
      send_cmd(1, 0, 64'h0, 12'(18 + i), 32'h1357_2468, 16'h00BC, 32'h600D_0000 + i, 0, 1);
      drain();
    end

    for (int half = 0; half < 2; half++) begin
      ready_rand = (half == 1);
      for (int i = 0; i < 20; i++) begin
        kind = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
        ht   = 1'($urandom_range(0, 1));
        if (kind == 2 && !ht) kind = 1;
        t = vita_time + 64'($urandom_range(0, 30)) - 64'd3;
        send_cmd(1'($urandom), ht, t, 12'($urandom), $urandom, 16'($urandom), $urandom,
                 kind, 1);
      end
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
